// File: rtl/clken_synth.sv
`default_nettype none
// ============================================================================
// Module   : clken_synth
// Purpose  : Runtime-programmable NUM_CH-channel phase-accumulator clock-enable
//            synthesiser with phase resync and a settle-gated locked flag.
// Revision : 1.0 - initial release
// ============================================================================
module clken_synth #(
   parameter int                       NUM_CH      = 3,
   parameter int                       ACC_W       = 32,
   parameter int                       LOCK_CYCLES = 16,
   parameter logic [NUM_CH*ACC_W-1:0]  INIT_INC    = '0,
   localparam int                      SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               refclk,
   input  logic               rst,
   input  logic               inc_we,
   input  logic [SEL_W-1:0]   inc_sel,
   input  logic [ACC_W-1:0]   inc_wdata,
   input  logic               sync,
   output logic [NUM_CH-1:0]  clken,
   output logic [NUM_CH-1:0]  outclk,
   output logic               locked
);

   localparam int                 c_cnt_w     = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_CYCLES - 1);
   localparam logic [ACC_W-1:0]   c_half      = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [SEL_W:0]     c_num_ch    = (SEL_W+1)'(NUM_CH);

   typedef enum logic [0:0] {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   logic [ACC_W-1:0]    r_acc [NUM_CH];
   logic [ACC_W-1:0]    r_inc [NUM_CH];
   logic [ACC_W:0]      w_sum [NUM_CH];
   logic [NUM_CH-1:0]   r_clken;
   logic [NUM_CH-1:0]   r_outclk;
   lock_state_t         r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_locked;

   logic                w_accept;
   logic                w_disturb;
   logic                w_gate;
   logic [ACC_W-1:0]    w_wdata;

   assign w_accept  = inc_we & ({1'b0, inc_sel} < c_num_ch);
   assign w_disturb = w_accept | sync;
   assign w_wdata   = (inc_wdata > c_half) ? c_half : inc_wdata;
   // Gate with the value locked takes on this edge so no pulse ever escapes while locked=0.
   assign w_gate    = ~w_disturb & ((r_state == LOCKED) | (r_cnt == c_lock_last));

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign w_sum[i] = {1'b0, r_acc[i]} + {1'b0, r_inc[i]};
      end
   endgenerate

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_acc[i] <= '0;
            r_inc[i] <= INIT_INC[i*ACC_W +: ACC_W];
         end
         r_clken  <= '0;
         r_outclk <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_acc[i]    <= sync ? '0 : w_sum[i][ACC_W-1:0];
            if (w_accept && (inc_sel == SEL_W'(i))) begin
               r_inc[i] <= w_wdata;
            end
            r_clken[i]  <= w_sum[i][ACC_W]   & w_gate;
            r_outclk[i] <= w_sum[i][ACC_W-1] & w_gate;
         end
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         r_state  <= UNLOCKED;
         r_cnt    <= '0;
         r_locked <= 1'b0;
      end else begin
         case (r_state)
            UNLOCKED: begin
               if (w_disturb) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_lock_last) begin
                  r_state  <= LOCKED;
                  r_locked <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            LOCKED: begin
               if (w_disturb) begin
                  r_state  <= UNLOCKED;
                  r_cnt    <= '0;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= UNLOCKED;
               r_cnt    <= '0;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign clken  = r_clken;
   assign outclk = r_outclk;
   assign locked = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_clken_synth.sv
`default_nettype none
// ============================================================================
// Module   : tb_clken_synth
// Purpose  : Scoreboard bench for clken_synth against a frequency/phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clken_synth;

   localparam int NCH  = 3;
   localparam int LOCK = 16;

   logic        refclk = 1'b0;
   logic        rst    = 1'b0;
   logic        inc_we = 1'b0;
   logic [1:0]  inc_sel = '0;
   logic [31:0] inc_wdata = '0;
   logic        sync = 1'b0;
   logic [2:0]  clken;
   logic [2:0]  outclk;
   logic        locked;

   clken_synth #(
      .NUM_CH      (NCH),
      .ACC_W       (32),
      .LOCK_CYCLES (LOCK),
      .INIT_INC    ('0)
   ) dut (
      .refclk    (refclk),
      .rst       (rst),
      .inc_we    (inc_we),
      .inc_sel   (inc_sel),
      .inc_wdata (inc_wdata),
      .sync      (sync),
      .clken     (clken),
      .outclk    (outclk),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   int checks = 0;
   int errors = 0;

   // Model: phase as an integer fraction of a full turn, lock as cycles since last disturbance
   longint unsigned m_acc [NCH];
   longint unsigned m_inc [NCH];
   int              m_since;
   logic [6:0]      exp_q [$];

   bit mon_en = 1'b0;
   int win_cnt [NCH];
   int win_adj1, win_diff01;
   bit prev1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_acc[c] = 0;
         m_inc[c] = 0;
      end
      m_since = 0;
      exp_q.delete();
   endtask

   task automatic clear_win();
      for (int c = 0; c < NCH; c++) win_cnt[c] = 0;
      win_adj1   = 0;
      win_diff01 = 0;
      prev1      = 1'b0;
   endtask

   // Called at a falling edge; drives one cycle of inputs and predicts the next edge.
   task automatic step(input bit we, input logic [1:0] sel, input logic [31:0] wd, input bit sy);
      longint unsigned total;
      bit              acc_ok, lk;
      logic [2:0]      e_clk, e_out;
      inc_we = we; inc_sel = sel; inc_wdata = wd; sync = sy;
      acc_ok = we && (int'(sel) < NCH);
      if (acc_ok || sy) m_since = 0;
      else if (m_since < LOCK) m_since++;
      lk = (m_since >= LOCK);
      e_clk = '0;
      e_out = '0;
      for (int c = 0; c < NCH; c++) begin
         total = m_acc[c] + m_inc[c];
         if (lk) begin
            e_clk[c] = (total >= 64'h1_0000_0000);
            e_out[c] = ((total % 64'h1_0000_0000) >= 64'h8000_0000);
         end
         m_acc[c] = sy ? 0 : (total % 64'h1_0000_0000);
      end
      if (acc_ok) m_inc[sel] = (longint'(wd) > 64'h8000_0000) ? 64'h8000_0000 : longint'(wd);
      exp_q.push_back({lk, e_out, e_clk});
      @(posedge refclk);
      @(negedge refclk);
      inc_we = 1'b0; sync = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 2'd0, 32'd0, 1'b0);
   endtask

   // Monitor: one output word per edge, popped and compared against the scoreboard
   always @(posedge refclk) begin
      logic [6:0] e;
      #1;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual=empty expected=entry at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("scoreboard", {25'd0, locked, outclk, clken}, {25'd0, e});
         end
         for (int c = 0; c < NCH; c++) if (clken[c]) win_cnt[c]++;
         if (clken[1] && prev1) win_adj1++;
         prev1 = clken[1];
         if (clken[0] != clken[1]) win_diff01++;
      end
   end

   initial begin
      model_reset();
      clear_win();
      repeat (5) @(negedge refclk);
      check("reset_outputs", {25'd0, locked, outclk, clken}, 32'd0);
      rst = 1'b1;
      mon_en = 1'b1;

      // Lock rises exactly LOCK edges after release
      idle(LOCK - 1);
      check("lock_not_yet", {31'd0, locked}, 32'd0);
      idle(1);
      check("lock_first", {31'd0, locked}, 32'd1);
      clear_win();
      idle(20);
      check("init_inc_zero", win_cnt[0] + win_cnt[1] + win_cnt[2], 32'd0);

      // Integer rate on ch0
      step(1'b1, 2'd0, 32'h4000_0000, 1'b0);
      idle(LOCK);
      clear_win();
      idle(40);
      check("int_rate_cnt0", win_cnt[0], 32'd10);
      check("int_rate_others", win_cnt[1] + win_cnt[2], 32'd0);

      // Reprogram while locked, then an out-of-range write
      step(1'b1, 2'd0, 32'h4000_0000, 1'b0);
      check("reprog_unlock", {31'd0, locked}, 32'd0);
      idle(LOCK - 1);
      check("reprog_still_unlocked", {31'd0, locked}, 32'd0);
      idle(1);
      check("reprog_relock", {31'd0, locked}, 32'd1);
      step(1'b1, 2'd3, 32'h1234_5678, 1'b0);
      check("bad_sel_keeps_lock", {31'd0, locked}, 32'd1);

      // Fractional rate 0.24 on ch1
      step(1'b1, 2'd1, 32'd1030792151, 1'b0);
      idle(LOCK);
      clear_win();
      idle(10000);
      checks++;
      if (win_cnt[1] < 2399 || win_cnt[1] > 2401) begin
         errors++;
         $display("FAIL frac_count actual=%0d expected=2400+-1", win_cnt[1]);
      end
      check("frac_no_adjacent", win_adj1, 32'd0);

      // Clamp on ch2
      step(1'b1, 2'd2, 32'hFFFF_FFFF, 1'b0);
      idle(LOCK);
      clear_win();
      idle(40);
      check("clamp_rate_cnt2", win_cnt[2], 32'd20);

      // Sync aligns ch0 and ch1
      step(1'b1, 2'd1, 32'h4000_0000, 1'b0);
      step(1'b0, 2'd0, 32'd0, 1'b1);
      check("sync_unlock", {31'd0, locked}, 32'd0);
      idle(LOCK);
      clear_win();
      idle(40);
      check("sync_aligned", win_diff01, 32'd0);
      check("sync_cnt1", win_cnt[1], 32'd10);

      // Simultaneous write and sync
      step(1'b1, 2'd0, 32'h2000_0000, 1'b1);
      idle(LOCK + 24);

      // Mid-run asynchronous reset between edges
      #2 rst = 1'b0;
      #1 check("async_reset_outputs", {25'd0, locked, outclk, clken}, 32'd0);
      mon_en = 1'b0;
      repeat (4) @(negedge refclk);
      model_reset();
      rst = 1'b1;
      mon_en = 1'b1;
      idle(LOCK + 8);
      check("post_reset_lock", {31'd0, locked}, 32'd1);
      clear_win();
      idle(20);
      check("post_reset_init_inc", win_cnt[0] + win_cnt[1] + win_cnt[2], 32'd0);

      // Randomised traffic: sparse writes (including out-of-range sel) and syncs
      for (int k = 0; k < 3000; k++) begin
         bit          we, sy;
         logic [1:0]  sel;
         logic [31:0] wd;
         we  = ($urandom_range(0, 99) < 2);
         sy  = ($urandom_range(0, 199) == 0);
         sel = 2'($urandom_range(0, 3));
         wd  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) >> $urandom_range(1, 8));
         step(we, sel, wd, sy);
      end

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/clken_synth.md
Name: clken_synth

Overview:
- Parametrised, runtime-programmable clock-enable synthesiser.
- Generalises the fixed three-output PLL to NUM_CH fractional channels driven from the single system clock.
- Each channel uses a phase accumulator to produce a one-cycle enable pulse and a near-50% square wave at refclk·inc/2^ACC_W.
- Provides phase resynchronisation, and a locked flag that is withheld after reset or reprogramming until the channels are settled.

Parameters:
- NUM_CH, 3: number of output channels (≥1).
- ACC_W, 32: phase accumulator width; frequency resolution is refclk/2^ACC_W.
- LOCK_CYCLES, 16: cycles of stable operation required before locked asserts (≥1).
- INIT_INC, {NUM_CH*ACC_W{1'b0}}: flattened reset increments; channel i occupies bits [i*ACC_W +: ACC_W].
- SEL_W (localparam): max(1, clog2(NUM_CH)).

Ports:
- refclk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- inc_we  in  1  increment write strobe
- inc_sel  in  SEL_W  channel index for the write
- inc_wdata  in  ACC_W  new phase increment
- sync  in  1  zero all accumulators (phase align)
- clken  out  NUM_CH  per-channel one-cycle enable pulses
- outclk  out  NUM_CH  per-channel square waves (accumulator MSB, registered)
- locked  out  1  channels settled, outputs valid

Behaviour:
- Reset (rst=0), asynchronous:
  - acc[i]=0, inc[i]=INIT_INC slice, clken=0, outclk=0, locked=0, lock counter=0.
  - Outputs go to 0 without a clock edge.
- Each edge, per channel: {carry, sum} = acc[i] + inc[i] (ACC_W+1 bits). acc[i] takes sum modulo 2^ACC_W.
- Output registers: clken[i] registers carry and is gated by locked; outclk[i] registers sum[ACC_W-1] and is gated by locked.
- Latency: one edge from accumulator wrap to the clken pulse. clken is never high for two consecutive cycles unless inc ≥ 2^(ACC_W-1).
- Write:
  - inc_we=1 with inc_sel<NUM_CH is accepted. inc[sel] updates on that edge and is used from the next cycle; acc is not disturbed (phase-continuous).
  - inc_sel≥NUM_CH: write ignored entirely, no lock disturbance.
  - Clamp: wdata > 2^(ACC_W-1) stores 2^(ACC_W-1), giving maximum rate refclk/2.
  - inc=0: channel frozen, clken=0, outclk holds the MSB of the frozen acc.
- sync=1: all acc[i] load 0 on that edge; clken and outclk register 0 on that edge.
- Lock state machine:
  - States UNLOCKED and LOCKED.
  - UNLOCKED: counter increments each cycle. When it reaches LOCK_CYCLES-1 the machine enters LOCKED and locked=1 on the next edge, i.e. locked first high LOCK_CYCLES edges after rst release.
  - LOCKED: an accepted write or sync returns to UNLOCKED, clears the counter, and sets locked=0 on the same edge.
  - Accepted write or sync while UNLOCKED clears the counter (restarts the count).
  - Counter saturates; no wrap.
- While locked=0, clken and outclk are held at 0 but the accumulators keep running.
- Simultaneous write and sync: both apply. acc is zeroed, the new inc is stored, and lock restarts.
- Simultaneous sync and reset: reset wins.

Test Plan:
- Reset: hold rst=0 for 5 cycles, then release → all outputs 0, locked rises exactly 16 edges after release, and clken stays 0 with INIT_INC=0.
- Integer rate (ACC_W=32): write ch0 inc=0x40000000, then wait for lock → clken[0] pulses every 4th cycle, outclk[0] runs 2 high/2 low, and other channels stay 0.
- Fractional rate: write ch1 inc=1030792151 (0.24) and run 10000 cycles after lock → 2400±1 clken[1] pulses with no adjacent pulses.
- Reprogram while locked: write ch0 → locked=0 on that edge, clken all 0 for 16 cycles, then locked=1. Write with inc_sel=3 (NUM_CH=3) → no change, locked stays 1.
- Clamp and sync: write 0xFFFFFFFF to ch2 → stored 0x80000000 and clken[2] pulses every 2nd cycle. Assert sync with ch0=ch1=0x40000000 → after relock, clken[0] and clken[1] pulse in the same cycles.
- Mid-run reset: drop rst between clock edges while channels are active → clken, outclk and locked go 0 immediately, and inc returns to INIT_INC after release.
